// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, flag bit indices, illegal-op fill and flag generation shared by alu_multicycle
package alu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_XOR = 3'b001,
    OP_SUB = 3'b010,
    OP_ADD = 3'b011,
    OP_CMP = 3'b100,
    OP_OR  = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } op_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic ALU_ILLEGAL_RESULT = 1'b1;
  // carry is the raw adder carry-out; for SUB/CMP it comes from a + ~b + 1, so 1 means no borrow
  function automatic logic [3:0] alu_flags(input op_t op, input logic res_msb, input logic res_zero,
                                           input logic carry, input logic a_msb, input logic b_msb);
    logic [3:0] f;
    logic       arith_sub;
    arith_sub = op == OP_SUB || op == OP_CMP;
    f = '0;
    f[FLAG_N] = res_msb;
    f[FLAG_Z] = res_zero;
    f[FLAG_C] = (op == OP_ADD || arith_sub) && carry;
    f[FLAG_V] = op == OP_ADD ? (a_msb == b_msb) && (res_msb != a_msb) :
                arith_sub    ? (a_msb != b_msb) && (res_msb != a_msb) : 1'b0;
    return op == OP_ILL ? 4'b0000 : f;
  endfunction
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: WIDTH-cycle unsigned shift-add multiplier, low WIDTH bits of the product
//   clk, rst_n : clock, async active-low reset (aborts a running multiply)
//   start      : capture a/b and begin
//   done       : high in the last iteration cycle; product is valid alongside it
//   product    : low WIDTH bits of a*b
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [WIDTH-1:0] w_acc_next;
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  // product is taken from the final partial sum so the caller can register it on the done edge
  assign done    = r_run && r_cnt == CW'(WIDTH - 1);
  assign product = w_acc_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
    end else if (r_run) begin
      r_run <= !done;
      r_cnt <= r_cnt + 1'b1;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_next;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU, single-cycle logic/arith ops and WIDTH-cycle shift-add MUL
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operation handshake; a, b, op captured on accept
//   out_valid/out_ready : result handshake; result, flags {N,Z,C,V}, wr_en held until drained
//   busy                : multiply in progress
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             wr_en,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
  state_t           r_state, w_next;
  op_t              w_op;
  logic             w_is_mul, w_accept, w_mul_done, w_carry;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_res, w_product;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_wr_en;
  // without the multiplier MUL decodes as illegal everywhere downstream
  assign w_op      = (op_t'(op) == OP_MUL && !MUL_EN) ? OP_ILL : op_t'(op);
  assign w_is_mul  = w_op == OP_MUL;
  assign in_ready  = r_state == S_IDLE || (r_state == S_DONE && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign busy      = r_state == S_MUL;
  assign out_valid = r_state == S_DONE;
  assign result    = r_result;
  assign flags     = r_flags;
  assign wr_en     = r_wr_en;
  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} + {1'b0, ~b} + 1'b1;
  assign w_carry   = w_op == OP_ADD ? w_sum[WIDTH] : w_diff[WIDTH];
  assign w_res     = w_op == OP_AND ? a & b :
                     w_op == OP_XOR ? a ^ b :
                     w_op == OP_OR  ? a | b :
                     w_op == OP_ADD ? w_sum[WIDTH-1:0] :
                     (w_op == OP_SUB || w_op == OP_CMP) ? w_diff[WIDTH-1:0] :
                     {WIDTH{ALU_ILLEGAL_RESULT}};
  generate
    if (MUL_EN) begin : g_mul
      mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_product)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_product  = '0;
    end
  endgenerate
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_MUL ? (w_mul_done ? S_DONE : S_MUL) :
             w_accept ? (w_is_mul ? S_MUL : S_DONE) :
             (r_state == S_DONE && out_ready) ? S_IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_wr_en  <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_flags  <= alu_flags(w_op, w_res[WIDTH-1], w_res == '0, w_carry, a[WIDTH-1], b[WIDTH-1]);
      r_wr_en  <= w_op != OP_CMP && w_op != OP_ILL;
    end else if (w_mul_done) begin
      r_result <= w_product;
      r_flags  <= alu_flags(OP_MUL, w_product[WIDTH-1], w_product == '0, 1'b0, 1'b0, 1'b0);
      r_wr_en  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (WIDTH=32 with MUL, WIDTH=8 without)
module tb_alu_multicycle;
  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic        w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, wr_en, busy;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        v8 = 1'b0, ordy8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  op8 = '0;
  logic        rdy8, ov8, we8, busy8;
  logic [7:0]  res8;
  logic [3:0]  fl8;

  exp_t q[$];
  exp_t e_mon;
  int   n_chk = 0, n_err = 0;
  int   rdy_mode = 1;
  int   g_wait = 0;
  int   bad;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags), .wr_en(wr_en), .busy(busy)
  );

  alu_multicycle #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(ordy8), .result(res8), .flags(fl8), .wr_en(we8), .busy(busy8)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] r, logic [3:0] f, logic w);
    exp_t e;
    e.r = r;
    e.f = f;
    e.w = w;
    return e;
  endfunction

  function automatic exp_t model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    exp_t        e;
    logic [32:0] s;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    e.w = 1'b1;
    case (o)
      3'd0: e.r = x & y;
      3'd1: e.r = x ^ y;
      3'd5: e.r = x | y;
      3'd6: e.r = x * y;
      3'd3: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[31:0];
        c = s[32];
        v = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      3'd2, 3'd4: begin
        e.r = x - y;
        c = x >= y;
        v = (x[31] != y[31]) && (e.r[31] != x[31]);
        e.w = o == 3'd2;
      end
      default: begin
        e.r = '1;
        e.w = 1'b0;
      end
    endcase
    e.f = {e.r[31], e.r == 32'd0, c, v};
    if (o == 3'd7) e.f = 4'b0000;
    return e;
  endfunction

  function automatic logic pick_ready();
    return rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
  endfunction

  // present an op and keep it until in_ready; expectation is queued for the accept edge
  task automatic send_exp(logic [2:0] o, logic [31:0] x, logic [31:0] y, exp_t e);
    int t;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    out_ready = pick_ready();
    #1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      out_ready = pick_ready();
      #1;
      t++;
    end
    g_wait = t;
    if (in_ready) q.push_back(e);
    else begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic send(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    send_exp(o, x, y, model(o, x, y));
  endtask

  task automatic run8(logic [2:0] o, logic [7:0] x, logic [7:0] y, logic [7:0] er, logic [3:0] ef, logic ew);
    @(negedge clk);
    v8 = 1'b1; op8 = o; a8 = x; b8 = y;
    #1;
    check("w8_in_ready", 64'(rdy8), 64'd1);
    @(negedge clk);
    v8 = 1'b0;
    #1;
    check("w8_out_valid", 64'(ov8), 64'd1);
    check("w8_result", 64'(res8), 64'(er));
    check("w8_flags", 64'(fl8), 64'(ef));
    check("w8_wr_en", 64'(we8), 64'(ew));
    check("w8_busy", 64'(busy8), 64'd0);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
      else begin
        e_mon = q.pop_front();
        check("sb_result", 64'(result), 64'(e_mon.r));
        check("sb_flags", 64'(flags), 64'(e_mon.f));
        check("sb_wr_en", 64'(wr_en), 64'(e_mon.w));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    send_exp(3'd3, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 4'b1001, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("add_latency1", 64'(out_valid), 64'd1);

    send_exp(3'd4, 32'd5, 32'd5, mk(32'h0, 4'b0110, 1'b0));
    send_exp(3'd2, 32'd3, 32'd5, mk(32'hFFFF_FFFE, 4'b1000, 1'b1));
    check("b2b_no_stall", 64'(g_wait), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("sub_valid_next", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1;
    check("drain_to_idle", 64'(out_valid), 64'd0);

    send_exp(3'd6, 32'h0001_0001, 32'h0001_0001, mk(32'h0002_0001, 4'b0000, 1'b1));
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (!busy || in_ready || out_valid) bad++;
    end
    check("mul_busy_window", 64'(bad), 64'd0);
    @(negedge clk);
    #1;
    check("mul_out_valid", 64'(out_valid), 64'd1);
    check("mul_busy_clear", 64'(busy), 64'd0);

    rdy_mode = 0;
    send_exp(3'd1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, mk(32'h0F0F_0F0F, 4'b0000, 1'b1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'd3; a = $urandom; b = $urandom;
      #1;
      check("stall_result", 64'(result), 64'h0F0F_0F0F);
      check("stall_flags", 64'(flags), 64'd0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall_drained", 64'(out_valid), 64'd0);

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) send(3'($urandom_range(0, 7)), $urandom, (i % 5 == 0) ? 32'h8000_0000 : $urandom);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rdy_mode = 1;
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      @(negedge clk);
      #2;
    end
    check("random_drained", 64'(q.size()), 64'd0);

    send(3'd3, 32'd1, 32'd1);
    send(3'd6, 32'h1234, 32'h5678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    check("pre_abort_result", 64'(result), 64'd2);
    check("pre_abort_busy", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy) bad++;
    end
    check("abort_no_result", 64'(bad), 64'd0);

    run8(3'd7, 8'h12, 8'h34, 8'hFF, 4'b0000, 1'b0);
    run8(3'd6, 8'h03, 8'h04, 8'hFF, 4'b0000, 1'b0);
    run8(3'd3, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b1);

    check("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, which sets the operand and result width (at least 8).
REQ-002 The block SHALL take parameter MUL_EN, default 1; when it is 1 the MUL op is implemented, and when it is 0 MUL is treated as illegal.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: operands and op are presented.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept an operation this cycle.
REQ-007 Port a SHALL be an input, WIDTH bits wide: operand A.
REQ-008 Port b SHALL be an input, WIDTH bits wide: operand B.
REQ-009 Port op SHALL be an input, 3 bits wide, encoded as: 000 AND, 001 XOR, 010 SUB, 011 ADD, 100 CMP, 101 OR, 110 MUL, 111 illegal.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: result and flags are valid.
REQ-011 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-012 Port result SHALL be an output, WIDTH bits wide: the registered result.
REQ-013 Port flags SHALL be an output, 4 bits wide: registered {N,Z,C,V}.
REQ-014 Port wr_en SHALL be an output, 1 bit wide: the result is meant for register writeback (0 for CMP and for illegal ops).
REQ-015 Port busy SHALL be an output, 1 bit wide: a multiply is in progress.

Function
REQ-016 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b and op SHALL be captured on that edge.
REQ-017 The FSM SHALL have three states: IDLE, MUL, DONE.
REQ-018 In IDLE, accepting a non-MUL op SHALL go to DONE, with out_valid=1 on the next cycle (latency 1).
REQ-019 In IDLE, accepting MUL SHALL go to MUL; the shift-add multiply SHALL take exactly WIDTH cycles, then go to DONE (out_valid asserted WIDTH+1 cycles after accept).
REQ-020 In DONE, result, flags and wr_en SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1 and no new accept, the FSM SHALL go to IDLE and out_valid SHALL drop on the next cycle.
REQ-022 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready), so back-to-back single-cycle ops sustain one result per cycle.
REQ-023 When a DONE drain coincides with a new accept, the FSM SHALL load the new op's result (non-MUL) or enter MUL (MUL, with out_valid=0 during the multiply).
REQ-024 in_ready SHALL be 0 in MUL; busy SHALL equal (state==MUL).
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-026 CMP SHALL compute A-B exactly as SUB, set flags identically, and set wr_en=0.
REQ-027 N SHALL be result[WIDTH-1], and Z SHALL be 1 when result==0.
REQ-028 For ADD, C SHALL be the carry-out and V SHALL be 1 when the operands have the same sign and the result's sign differs.
REQ-029 For SUB/CMP, C SHALL be 1 when A>=B unsigned (no borrow) and V SHALL be 1 when the operands' signs differ and the result's sign differs from A's.
REQ-030 For AND, OR, XOR and MUL, C and V SHALL be 0.
REQ-031 For an illegal op, result SHALL be all ones, flags 0000 and wr_en=0, with latency 1.
REQ-032 in_valid held high while in_ready=0 SHALL have no effect, and the inputs SHALL be re-sampled only on the accept edge.

Reset
REQ-033 On rst_n=0 the block SHALL asynchronously force state=IDLE, out_valid=0, result=0, flags=0000, wr_en=0 and busy=0.
REQ-034 Assertion of rst_n mid-multiply SHALL abort the operation, and no result SHALL be emitted after release.
REQ-035 Reset release SHALL be synchronised externally, and in_ready SHALL be 1 on the first edge after release.

Structure
REQ-036 Package alu_pkg SHALL hold the op_t enum (3-bit encodings above), the flag bit indices N=3, Z=2, C=1, V=0, and the ALU_ILLEGAL_RESULT fill constant.
REQ-037 The shift-add multiplier SHALL be sub-module mul_shift_add, parameterised by WIDTH, with start, done, a, b and product ports, and it SHALL be absent when MUL_EN=0.
REQ-038 Flag generation SHALL be a combinational function in alu_pkg that the top-level block registers.

Verification (WIDTH=32 unless stated)
REQ-039 Applying ADD 0x7FFFFFFF+1 with out_ready=1 SHALL give, one cycle later, result 0x80000000, flags 1001 and wr_en=1.
REQ-040 Applying CMP 5,5 then SUB 3,5 back-to-back SHALL give 0x00000000/0110/wr_en=0, then 0xFFFFFFFE/1000/wr_en=1, on consecutive cycles.
REQ-041 Applying MUL 0x00010001*0x00010001 SHALL hold busy=1 and in_ready=0 for 32 cycles, then give result 0x00020001 and flags 0000.
REQ-042 Applying XOR 0xF0F0F0F0^0xFFFFFFFF with out_ready=0 for 5 cycles SHALL hold result 0x0F0F0F0F, flags 0000 and in_ready=0, then drain when out_ready rises.
REQ-043 Asserting rst_n=0 at multiply cycle 10 SHALL drive all outputs to 0 at once, and after release no result SHALL appear and in_ready SHALL be 1.
REQ-044 An illegal op (op=111) at WIDTH=8 SHALL give result 0xFF, flags 0000 and wr_en=0.
